// File: rtl/arc4_crack_ctrl_if.sv
// rtl/arc4_crack_ctrl_if.sv - signal bundle between the key-search controller, arc4, pt_mem and the top level
//
// Groups every controller signal except clk/rst.
//   master : the controller (drives rdy/key_out/key_valid, a4_en/a4_key, muxed pt_* bus)
//   slave  : the surroundings (top level en, arc4 status and pt_mem port, pt_mem read data)
interface arc4_crack_ctrl_if;
  logic        en;
  logic        rdy;
  logic [23:0] key_out;
  logic        key_valid;
  logic        a4_en;
  logic        a4_rdy;
  logic [23:0] a4_key;
  logic [7:0]  a4_pt_addr;
  logic [7:0]  a4_pt_wrdata;
  logic        a4_pt_wren;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_wrdata;
  logic        pt_wren;
  logic [7:0]  pt_rddata;

  modport master (
    input  en, a4_rdy, a4_pt_addr, a4_pt_wrdata, a4_pt_wren, pt_rddata,
    output rdy, key_out, key_valid, a4_en, a4_key, pt_addr, pt_wrdata, pt_wren
  );

  modport slave (
    output en, a4_rdy, a4_pt_addr, a4_pt_wrdata, a4_pt_wren, pt_rddata,
    input  rdy, key_out, key_valid, a4_en, a4_key, pt_addr, pt_wrdata, pt_wren
  );
endinterface

// File: rtl/arc4_crack_ctrl.sv
// rtl/arc4_crack_ctrl.sv - arc4 key-search controller with printable-plaintext check
//
// Steps candidate keys KEY_START, KEY_START+KEY_STEP, ... up to KEY_END, launches arc4 for
// each, then takes pt_mem over and scans the length-prefixed plaintext for bytes 8'h20..8'h7E.
// Stops on the first fully printable message or when the range runs out.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   bus.en / bus.rdy  : start request, honoured while rdy=1 (idle or done)
//   bus.key_out       : last key tried, the found key when key_valid=1
//   bus.key_valid     : key_out decrypts to printable text
//   bus.a4_en/a4_key  : one-cycle arc4 start pulse and the candidate key
//   bus.a4_rdy        : arc4 ready
//   bus.a4_pt_*       : arc4's pt_mem port, forwarded while arc4 runs
//   bus.pt_*          : muxed pt_mem port, pt_rddata valid one cycle after pt_addr
//
// Optional: define CRACK_EARLY_ABORT_EN to reject a key at its first non-printable byte
// instead of always scanning the whole message.
module arc4_crack_ctrl #(
  parameter logic [23:0] KEY_START = 24'h000000,
  parameter logic [23:0] KEY_END   = 24'hFFFFFF,
  parameter logic [23:0] KEY_STEP  = 24'd1
) (
  input  logic               clk,
  input  logic               rst,
  arc4_crack_ctrl_if.master  bus
);

`ifdef CRACK_EARLY_ABORT_EN
  localparam bit EARLY_ABORT = 1'b1;
`else
  localparam bit EARLY_ABORT = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, LAUNCH, SETTLE, RUN, RDLEN, CHKLEN, RDCHR, CHKCHR, NEXT, DONE
  } state_t;

  state_t      state;
  logic [23:0] cur_key;
  logic [7:0]  len;
  logic [7:0]  idx;
  logic        bad;

  logic [24:0] next_key;
  logic        chr_ok;
  logic        a4_owns_pt;

  // 25-bit sum so the range check can never be fooled by a 24-bit wrap.
  assign next_key   = {1'b0, cur_key} + {1'b0, KEY_STEP};
  assign chr_ok     = (bus.pt_rddata >= 8'h20) && (bus.pt_rddata <= 8'h7E);
  assign a4_owns_pt = (state == LAUNCH) || (state == SETTLE) || (state == RUN);

  assign bus.pt_addr   = a4_owns_pt ? bus.a4_pt_addr   : ((state == RDLEN) ? 8'd0 : idx);
  assign bus.pt_wrdata = a4_owns_pt ? bus.a4_pt_wrdata : 8'd0;
  assign bus.pt_wren   = a4_owns_pt ? bus.a4_pt_wren   : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.rdy       <= 1'b1;
      bus.key_valid <= 1'b0;
      bus.key_out   <= KEY_START;
      bus.a4_en     <= 1'b0;
      bus.a4_key    <= KEY_START;
      cur_key       <= KEY_START;
      len           <= 8'd0;
      idx           <= 8'd0;
      bad           <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.en) begin
            state         <= LAUNCH;
            bus.rdy       <= 1'b0;
            bus.key_valid <= 1'b0;
            cur_key       <= KEY_START;
          end
        end
        LAUNCH: begin
          if (bus.a4_rdy) begin
            bus.a4_en  <= 1'b1;
            bus.a4_key <= cur_key;
            state      <= SETTLE;
          end
        end
        // arc4 only drops a4_rdy after it has seen the pulse, so skip one cycle.
        SETTLE: begin
          bus.a4_en <= 1'b0;
          state     <= RUN;
        end
        RUN: begin
          if (bus.a4_rdy) state <= RDLEN;
        end
        RDLEN: state <= CHKLEN;
        CHKLEN: begin
          len <= bus.pt_rddata;
          idx <= 8'd1;
          bad <= 1'b0;
          if (bus.pt_rddata == 8'd0) begin
            bus.key_out   <= cur_key;
            bus.key_valid <= 1'b1;
            bus.rdy       <= 1'b1;
            state         <= DONE;
          end else begin
            state <= RDCHR;
          end
        end
        RDCHR: state <= CHKCHR;
        CHKCHR: begin
          if (!chr_ok) bad <= 1'b1;
          if (!chr_ok && EARLY_ABORT) begin
            state <= NEXT;
          end else if (idx == len) begin
            // bad is sticky from earlier bytes; chr_ok covers the final byte.
            if (bad || !chr_ok) begin
              state <= NEXT;
            end else begin
              bus.key_out   <= cur_key;
              bus.key_valid <= 1'b1;
              bus.rdy       <= 1'b1;
              state         <= DONE;
            end
          end else begin
            idx   <= idx + 8'd1;
            state <= RDCHR;
          end
        end
        NEXT: begin
          bus.key_out <= cur_key;
          if (next_key > {1'b0, KEY_END}) begin
            bus.key_valid <= 1'b0;
            bus.rdy       <= 1'b1;
            state         <= DONE;
          end else begin
            cur_key <= next_key[23:0];
            state   <= LAUNCH;
          end
        end
        default: begin
          bus.rdy <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
